// File: rtl/spi_tx_channel.sv
// FIFO-buffered SPI transmit channel: each word goes out as an address header plus data, MSB first.
// Defining SPI_TX_PARITY_EN appends an even-parity bit to every frame.
module spi_tx_channel #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         TX_CLK,
  input  logic                         RST,
  input  logic [WORD_W-1:0]            DATA,
  input  logic                         ENA,
  input  logic [ADDR_W-1:0]            ADDR,
  input  logic                         RX_STOP,
  input  logic                         CLR_OVF,
  output logic                         TX_DATA,
  output logic                         TX_LOAD,
  output logic                         BUSY,
  output logic [$clog2(FIFO_DEPTH):0]  LEVEL,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic                         OVERFLOW
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef SPI_TX_PARITY_EN
  localparam int FRAME_L = ADDR_W + WORD_W + 1;
`else
  localparam int FRAME_L = ADDR_W + WORD_W;
`endif
  localparam int CNT_W = $clog2(FRAME_L);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level, level_nxt;
  logic               full, empty, ovf;
  logic [FRAME_L-1:0] shreg, frame_word;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit, pop, wr_ok, drop;

  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(FRAME_L - 1));
  // A new frame may start in the last-bit cycle of the current one, giving gapless streaming.
  assign pop   = !empty && !RX_STOP && ((state == IDLE) || last_bit);
  assign wr_ok = ENA && (!full || pop);
  assign drop  = ENA && full && !pop;

`ifdef SPI_TX_PARITY_EN
  assign frame_word = {ADDR, mem[rd_ptr], ^{ADDR, mem[rd_ptr]}};
`else
  assign frame_word = {ADDR, mem[rd_ptr]};
`endif

  always_ff @(posedge TX_CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = pop ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = level;
    if (wr_ok && !pop)      level_nxt = level + 1'b1;
    else if (!wr_ok && pop) level_nxt = level - 1'b1;
  end

  always_ff @(posedge TX_CLK) begin
    if (wr_ok) mem[wr_ptr] <= DATA;
  end

  always_ff @(posedge TX_CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
      empty <= (level_nxt == '0);
      // A dropped write outranks a simultaneous clear so no overflow event is lost.
      if (drop)         ovf <= 1'b1;
      else if (CLR_OVF) ovf <= 1'b0;
    end
  end

  always_ff @(posedge TX_CLK or posedge RST) begin
    if (RST) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (pop) begin
      shreg <= frame_word;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
    end
  end

  assign TX_DATA  = (state == SHIFT) && shreg[FRAME_L-1];
  assign TX_LOAD  = last_bit;
  assign BUSY     = (state == SHIFT);
  assign LEVEL    = level;
  assign FULL     = full;
  assign EMPTY    = empty;
  assign OVERFLOW = ovf;

endmodule

// File: tb/tb_spi_tx_channel.sv
// Self-checking bench for spi_tx_channel: a scoreboard of expected serial bits plus
// table-driven single frames and hand-written sequences for streaming, overflow, stop and reset.
module tb_spi_tx_channel;

`ifdef SPI_TX_PARITY_EN
  localparam int  FL  = 20;
  localparam bit  PAR = 1'b1;
`else
  localparam int  FL  = 19;
  localparam bit  PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        ena = 1'b0;
  logic [2:0]  addr = '0;
  logic        rx_stop = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        tx_data, tx_load, busy, full, empty, overflow;
  logic [4:0]  level;

  spi_tx_channel dut (
    .TX_CLK(clk), .RST(rst), .DATA(data), .ENA(ena), .ADDR(addr),
    .RX_STOP(rx_stop), .CLR_OVF(clr_ovf), .TX_DATA(tx_data), .TX_LOAD(tx_load),
    .BUSY(busy), .LEVEL(level), .FULL(full), .EMPTY(empty), .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic d; logic ld;} exp_bit_t;
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [18:0] exp_hd;
    logic        exp_par;
  } vec_t;

  exp_bit_t sb[$];
  exp_bit_t mon_e;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0, rise_cnt = 0, load_cnt = 0;
  logic prev_busy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushBits(input logic [18:0] hd, input logic par);
    for (int i = 18; i >= 0; i--) sb.push_back('{d: hd[i], ld: (i == 0) && !PAR});
    if (PAR) sb.push_back('{d: par, ld: 1'b1});
  endtask

  task automatic pushFrame(input logic [2:0] a, input logic [15:0] d);
    logic [18:0] hd;
    hd = {a, d};
    pushBits(hd, ^hd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one write for a single cycle; callers sit at posedge+1 so back-to-back calls stay contiguous.
  task automatic applyStimulus(input logic [2:0] a, input logic [15:0] d, input bit push);
    addr = a;
    data = d;
    ena  = 1'b1;
    if (push) pushFrame(a, d);
    step();
    ena  = 1'b0;
  endtask

  task automatic waitQueueEmpty(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d pending bits expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic waitBusy(input string name, input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      step();
      n++;
    end
    checkOutput(name, busy, 1);
  endtask

  // Serial monitor: every busy cycle must match the next scoreboard bit.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        busy_cnt++;
        if (!prev_busy) rise_cnt++;
        if (tx_load) load_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_bit: got tx_data=%0b expected no frame at %0t", tx_data, $time);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("frame_bit", tx_data, mon_e.d);
          checkOutput("frame_load", tx_load, mon_e.ld);
        end
      end else begin
        checkOutput("idle_lines", {tx_data, tx_load}, 0);
      end
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  initial begin
    vec_t vecs[5];
    int b0, r0, l0, n;

    vecs[0] = '{3'h1, 16'hA5C3, 19'b001_1010010111000011, 1'b1};
    vecs[1] = '{3'h1, 16'h0001, 19'b001_0000000000000001, 1'b0};
    vecs[2] = '{3'h7, 16'hFFFF, 19'b111_1111111111111111, 1'b1};
    vecs[3] = '{3'h0, 16'h0000, 19'b000_0000000000000000, 1'b0};
    vecs[4] = '{3'h5, 16'h8001, 19'b101_1000000000000001, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_lines", {tx_data, tx_load}, 0);

    // Single frames from the table, one at a time.
    for (int i = 0; i < 5; i++) begin
      b0 = busy_cnt; r0 = rise_cnt; l0 = load_cnt;
      addr = vecs[i].addr;
      pushBits(vecs[i].exp_hd, vecs[i].exp_par);
      applyStimulus(vecs[i].addr, vecs[i].data, 1'b0);
      checkOutput("vec_level_after_write", level, 1);
      waitQueueEmpty("vec_frame", 60);
      checkOutput("vec_busy_after_frame", busy, 0);
      checkOutput("vec_level_after_frame", level, 0);
      checkOutput("vec_empty_after_frame", empty, 1);
      checkOutput("vec_busy_cycles", busy_cnt - b0, FL);
      checkOutput("vec_busy_rises", rise_cnt - r0, 1);
      checkOutput("vec_loads", load_cnt - l0, 1);
    end

    // Gapless stream of four frames.
    b0 = busy_cnt; r0 = rise_cnt; l0 = load_cnt;
    applyStimulus(3'h3, 16'h1357, 1'b1);
    applyStimulus(3'h3, 16'hBEEF, 1'b1);
    applyStimulus(3'h3, 16'h0F0F, 1'b1);
    applyStimulus(3'h3, 16'hC001, 1'b1);
    waitQueueEmpty("stream", 200);
    checkOutput("stream_busy_cycles", busy_cnt - b0, 4 * FL);
    checkOutput("stream_busy_rises", rise_cnt - r0, 1);
    checkOutput("stream_loads", load_cnt - l0, 4);
    checkOutput("stream_busy_end", busy, 0);

    // Fill under RX_STOP, overflow, clear priority, full-with-pop write, then drain.
    rx_stop = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(3'h2, 16'h1000 + 16'(i * 257), 1'b1);
    applyStimulus(3'h2, 16'hDEAD, 1'b0);
    checkOutput("ovf_level", level, 16);
    checkOutput("ovf_full", full, 1);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_no_frame", busy, 0);
    clr_ovf = 1'b1;
    applyStimulus(3'h2, 16'hDEAF, 1'b0);
    checkOutput("ovf_set_wins", overflow, 1);
    step();
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);
    rx_stop = 1'b0;
    applyStimulus(3'h2, 16'h7E57, 1'b1);
    checkOutput("fullpop_level", level, 16);
    checkOutput("fullpop_full", full, 1);
    checkOutput("fullpop_ovf", overflow, 0);
    checkOutput("fullpop_busy", busy, 1);
    waitQueueEmpty("drain", 17 * FL + 40);
    checkOutput("drain_level", level, 0);
    checkOutput("drain_empty", empty, 1);

    // RX_STOP raised mid-frame: frame completes, next one waits.
    applyStimulus(3'h4, 16'h1234, 1'b1);
    applyStimulus(3'h4, 16'h8765, 1'b1);
    waitBusy("stop_first_busy", 10);
    repeat (5) step();
    rx_stop = 1'b1;
    n = 0;
    while (!tx_load && n < 40) begin
      step();
      n++;
    end
    checkOutput("stop_load_seen", tx_load, 1);
    step();
    checkOutput("stop_idle", busy, 0);
    checkOutput("stop_level", level, 1);
    repeat (8) step();
    checkOutput("stop_still_idle", busy, 0);
    checkOutput("stop_pending_bits", sb.size(), FL);
    rx_stop = 1'b0;
    step();
    checkOutput("stop_resume", busy, 1);
    waitQueueEmpty("stop_second", 60);

    // Asynchronous reset while bit 7 of a frame is on the line.
    applyStimulus(3'h6, 16'hFFFF, 1'b1);
    applyStimulus(3'h6, 16'h0F0F, 1'b1);
    waitBusy("rst_mid_busy", 10);
    repeat (6) step();
    checkOutput("rst_mid_bit7", tx_data, 1);
    checkOutput("rst_mid_level", level, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("rst_mid_txdata", tx_data, 0);
    checkOutput("rst_mid_txload", tx_load, 0);
    checkOutput("rst_mid_busy0", busy, 0);
    checkOutput("rst_mid_level0", level, 0);
    checkOutput("rst_mid_empty", empty, 1);
    step();
    rst = 1'b0;
    repeat (3) step();
    checkOutput("rst_mid_quiet", busy, 0);

    // Channel recovers after reset.
    applyStimulus(3'h1, 16'hA5C3, 1'b1);
    waitQueueEmpty("post_rst", 60);
    checkOutput("post_rst_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
